pipe_stage_elastic: RTL
=======================

// Module: pipe_stage_elastic
// PURPOSE
//  Parametrised, elastic pipeline-stage register that replaces the fixed ID/EX-style latch.
//  Carries a data payload (instruction, RF operands) and a control bundle (ALU op, mux
//  selects, MEM/RF enables) with valid/ready handshaking, an optional 2-entry skid buffer
//  and synchronous flush that inserts a bubble. Instantiated between every CPU pipe stage.
// PARAMETERS
//  DATA_W  32  payload width; never cleared by flush, don't-care when out_valid=0
//  CTRL_W  18  control-bundle width; forced to 0 whenever out_valid=0 (bubble = NOP)
//  SKID    1   1: 2-entry skid buffer, registered in_ready; 0: single register, comb in_ready
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  flush      in   1        sync squash of all held beats (branch/jump redirect)
//  in_valid   in   1        upstream beat valid
//  in_ready   out  1        stage can accept; beat transfers when in_valid&&in_ready
//  in_data    in   DATA_W   upstream payload
//  in_ctrl    in   CTRL_W   upstream control bundle
//  out_valid  out  1        downstream beat valid
//  out_ready  in   1        downstream accepts; beat leaves when out_valid&&out_ready
//  out_data   out  DATA_W   payload to next stage
//  out_ctrl   out  CTRL_W   control bundle to next stage (0 when !out_valid)
//  occupancy  out  2        beats held: 0,1,2 (2 only when SKID=1)
// BEHAVIOUR
//  - Reset (rst_n=0, any time, async): out_valid=0, out_data=0, out_ctrl=0, occupancy=0,
//    skid empty, in_ready=1. Holds while rst_n=0; first accept possible on first edge after release.
//  - Latency: accepted beat appears on out_* the cycle after acceptance when stage was empty.
//  - Order preserved; no beat lost or duplicated; throughput 1 beat/cycle with out_ready=1.
//  - While out_valid=1 && out_ready=0: out_data/out_ctrl stable.
//  - SKID=1: in_ready = (skid empty), registered; no comb path out_ready->in_ready or in_*->out_*.
//    Main reg loads input if main empty or out_ready=1; else accepted beat goes to skid.
//    If out_ready=1 and skid full: main <= skid, skid empties, in_ready returns 1 next cycle.
//    Skid full and in_valid=1: producer holds beat (in_ready=0).
//  - SKID=0: in_ready = !out_valid || out_ready (combinational); occupancy max 1.
//  - flush=1 (highest priority after reset): next cycle out_valid=0, out_ctrl=0, occupancy=0,
//    skid empty, in_ready=1. A beat handshaked in the flush cycle is consumed and dropped.
//    Beat handshaked out in the flush cycle counts as delivered. out_data holds.
//  - flush and out_ready both 1 with 2 beats held: both discarded except main beat delivered.
//  - out_ctrl is gated: equals registered ctrl when out_valid=1, else 0 (downstream never
//    sees stale MEM_write / RF_write_en).
//  - occupancy = main_valid + skid_valid, updated each edge.
// TESTING
//  1 Reset: drop rst_n mid-stream with 2 beats held -> out_valid=0, out_ctrl=0, occupancy=0,
//    in_ready=1 immediately (no clk edge needed).
//  2 Stream: out_ready=1, in_data=1..8 back-to-back -> out_data 1..8 one cycle later, no gaps.
//  3 Backpressure (SKID=1): out_ready=0, offer A,B,C -> out_data=A held, B in skid,
//    occupancy=2, in_ready=0, C held; raise out_ready -> A,B,C out on consecutive cycles.
//  4 Flush with occupancy=2 and in_valid=1 (D) -> next cycle out_valid=0, out_ctrl=0,
//    occupancy=0, in_ready=1; D never appears on out.
//  5 SKID=0 instance: in_ready tracks !out_valid||out_ready same cycle; stream 1/cycle.
//  6 Random in_valid/out_ready/flush (10k cycles, both SKID values) vs scoreboard:
//    in-order, no loss/dup except flushed beats, out_ctrl==0 whenever out_valid=0.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// pipe_stage_elastic
//
// Elastic register slice placed between CPU pipeline stages. It carries a
// payload (instruction word, register-file operands) and a control bundle
// (ALU op, mux selects, memory and register-file enables) under a
// valid/ready handshake.
//
// There are two build options:
//   SKID=1 : a main register plus a one-beat skid register. in_ready comes
//            straight from a flop, so there is no combinational path from
//            out_ready to in_ready, or from in_* to out_*.
//   SKID=0 : a single register. in_ready = !out_valid || out_ready, which is
//            combinational, and at most one beat is held.
//
// flush is a synchronous squash for branch and jump redirects. On the next
// edge it empties the slice. The payload register keeps its value, but
// out_ctrl is gated to zero, so the bubble looks like a NOP downstream.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   flush      in   1        drop every held beat and any beat offered this cycle
//   in_valid   in   1        upstream beat valid
//   in_ready   out  1        slice can take a beat (transfer on valid && ready)
//   in_data    in   DATA_W   upstream payload
//   in_ctrl    in   CTRL_W   upstream control bundle
//   out_valid  out  1        downstream beat valid
//   out_ready  in   1        downstream accepts (beat leaves on valid && ready)
//   out_data   out  DATA_W   payload to the next stage (don't-care when !out_valid)
//   out_ctrl   out  CTRL_W   control bundle to the next stage, 0 when !out_valid
//   occupancy  out  2        number of beats held: 0, 1 or 2
// ---------------------------------------------------------------------------
module pipe_stage_elastic #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 18,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    // Main register: this is always the beat presented downstream.
    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;

    // The skid register is only ever full while the main register is full.
    logic              skid_valid;

    logic              in_fire;

    assign in_fire = in_valid && in_ready;

    generate
        if (SKID) begin : g_skid
            logic [DATA_W-1:0] skid_data;
            logic [CTRL_W-1:0] skid_ctrl;

            logic main_load_in;
            logic main_load_skid;
            logic skid_load;
            logic main_valid_nxt;
            logic skid_valid_nxt;

            // While the skid register is full, in_ready is low, so no beat can
            // arrive. The only thing that can happen then is a refill of the
            // main register from the skid register.
            always_comb begin
                // NOTE: every output of this block gets a default first, so no
                // path through the if/else leaves a signal unassigned and no latch is inferred.
                main_load_in   = 1'b0;
                main_load_skid = 1'b0;
                skid_load      = 1'b0;
                main_valid_nxt = main_valid;
                skid_valid_nxt = skid_valid;

                if (flush) begin
                    // Both registers are cleared. If out_ready was high, the main
                    // beat has already been delivered this cycle. A beat accepted
                    // this cycle is dropped.
                    main_valid_nxt = 1'b0;
                    skid_valid_nxt = 1'b0;
                end else if (skid_valid) begin
                    if (out_ready) begin
                        main_load_skid = 1'b1;
                        main_valid_nxt = 1'b1;
                        skid_valid_nxt = 1'b0;
                    end
                end else if (in_fire) begin
                    if (!main_valid || out_ready) begin
                        main_load_in   = 1'b1;
                        main_valid_nxt = 1'b1;
                    end else begin
                        // Downstream is stalled: park the new beat in the skid register.
                        skid_load      = 1'b1;
                        skid_valid_nxt = 1'b1;
                    end
                end else if (out_ready) begin
                    main_valid_nxt = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                    main_data  <= '0;
                    main_ctrl  <= '0;
                end else begin
                    // NOTE: state registers use non-blocking assignment, so every
                    // flop samples the values that were present before the edge.
                    main_valid <= main_valid_nxt;
                    skid_valid <= skid_valid_nxt;
                    if (main_load_in) begin
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                    end else if (main_load_skid) begin
                        main_data <= skid_data;
                        main_ctrl <= skid_ctrl;
                    end
                end
            end

            // NOTE: the skid payload has no reset. It is only read when
            // skid_valid is set, and skid_valid is reset, so clearing the
            // payload itself would only add reset fan-out.
            always_ff @(posedge clk) begin
                if (skid_load) begin
                    skid_data <= in_data;
                    skid_ctrl <= in_ctrl;
                end
            end

            assign in_ready = !skid_valid;
        end else begin : g_single
            assign skid_valid = 1'b0;
            assign in_ready   = !main_valid || out_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_valid <= 1'b0;
                    main_data  <= '0;
                    main_ctrl  <= '0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                end else if (in_fire) begin
                    main_valid <= 1'b1;
                    main_data  <= in_data;
                    main_ctrl  <= in_ctrl;
                end else if (out_ready) begin
                    main_valid <= 1'b0;
                end
            end
        end
    endgenerate

    assign out_valid = main_valid;
    assign out_data  = main_data;
    // Gate the control bundle so downstream never acts on stale write enables.
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    // Invariants for simulation.
    a_skid_implies_main : assert property (@(posedge clk) disable iff (!rst_n)
        skid_valid |-> main_valid);

    a_hold_under_stall : assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready && !flush) |=>
            (out_valid && $stable(out_data) && $stable(out_ctrl)));

    a_bubble_is_nop : assert property (@(posedge clk) disable iff (!rst_n)
        !out_valid |-> (out_ctrl == '0));

endmodule
